// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer states, ALU code map, write-back and PC source encodings
package cpu_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, RETIRE, FAULT} state_t;
    typedef enum logic [2:0] {CL_DP, CL_CMP, CL_B, CL_BL, CL_LDR, CL_STR, CL_NONE} op_class_t;
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_CMP = 8;
    localparam int unsigned ALU_TST = 9;
    localparam int unsigned ALU_TEQ = 10;
    localparam int unsigned ALU_CMPI = 13;
    localparam int unsigned ALU_B = 31;
    localparam int unsigned ALU_BL = 32;
    localparam int unsigned ALU_LDR = 41;
    localparam int unsigned ALU_STR = 42;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic PC_INC = 1'b0;
    localparam logic PC_BR = 1'b1;
    // Data-processing codes occupy 0-7 plus 11 and 12; the rest of 8-13 only set flags.
    function automatic op_class_t classify(input int unsigned code);
        return code <= ALU_ADD + 7 || code == 11 || code == 12 ? CL_DP :
               code == ALU_CMP || code == ALU_TST || code == ALU_TEQ || code == ALU_CMPI ? CL_CMP :
               code == ALU_B ? CL_B :
               code == ALU_BL ? CL_BL :
               code == ALU_LDR ? CL_LDR :
               code == ALU_STR ? CL_STR : CL_NONE;
    endfunction
endpackage

// File: rtl/cpu_control_fsm_timer.sv
// mem_wait_timer: counts stalled handshake cycles and flags the cycle the limit is hit
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic timeout
);
    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count_en && !ready) cnt <= cnt + 1'b1;
    // A ready on the limit cycle suppresses the timeout.
    assign timeout = count_en && !ready && cnt == LAST;
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle instruction sequencer driving CPU strobes and memory handshakes
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CODE_W = 11,
    parameter int CNT_W = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] alu_code,
    input  logic              execute_flag,
    input  logic              cpsr_enable,
    input  logic              halt,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              ir_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              alu_enable,
    output logic              cpsr_write,
    output logic              reg_write,
    output logic [1:0]        wb_sel,
    output logic              link_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              mem_fault,
    output logic [CNT_W-1:0]  instr_retired
);
    state_t state, next_state;
    logic [CODE_W-1:0] code_q;
    logic flag_q, s_q, timeout;
    op_class_t cls, dec_cls;
    assign dec_cls = execute_flag ? classify(32'(alu_code)) : CL_NONE;
    assign cls = flag_q ? classify(32'(code_q)) : CL_NONE;
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != FETCH && state != MEM),
        .count_en (imem_req || dmem_req),
        .ready    (state == MEM ? dmem_ready : imem_ready),
        .timeout  (timeout)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= FETCH;
            code_q <= '0;
            flag_q <= 1'b0;
            s_q <= 1'b0;
            instr_retired <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                code_q <= alu_code;
                flag_q <= execute_flag;
                s_q <= cpsr_enable;
            end
            if (pc_write) instr_retired <= instr_retired + 1'b1;
        end
    always_comb begin
        next_state = state;
        case (state)
            FETCH:     next_state = halt ? FETCH : imem_ready ? DECODE : timeout ? FAULT : FETCH;
            DECODE:    next_state = dec_cls == CL_NONE ? RETIRE : EXECUTE;
            EXECUTE:   next_state = cls == CL_DP ? WRITEBACK :
                                    cls == CL_B || cls == CL_BL ? FETCH :
                                    cls == CL_LDR || cls == CL_STR ? MEM : RETIRE;
            MEM:       next_state = dmem_ready ? (cls == CL_LDR ? WRITEBACK : RETIRE) :
                                    timeout ? FAULT : MEM;
            WRITEBACK: next_state = RETIRE;
            RETIRE:    next_state = FETCH;
            default:   next_state = FAULT;
        endcase
    end
    // The fetch request is gated by rst so an abandoned handshake drops immediately.
    always_comb begin
        imem_req = state == FETCH && !halt && !rst;
        ir_write = state == DECODE;
        dmem_req = state == MEM;
        dmem_we = dmem_req && cls == CL_STR;
        alu_enable = state == EXECUTE;
        cpsr_write = alu_enable && (cls == CL_CMP || (cls == CL_DP && s_q));
        link_write = alu_enable && cls == CL_BL;
        reg_write = state == WRITEBACK || link_write;
        wb_sel = link_write ? WB_LINK : state == WRITEBACK && cls == CL_LDR ? WB_MEM : WB_ALU;
        pc_src = alu_enable && (cls == CL_B || cls == CL_BL) ? PC_BR : PC_INC;
        pc_write = state == RETIRE || pc_src == PC_BR;
        mem_fault = state == FAULT;
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: randomized scoreboard bench for the CPU control sequencer
module tb_cpu_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [10:0] alu_code = '0;
    logic execute_flag = 1'b0, cpsr_enable = 1'b0, halt = 1'b1, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, ir_write, dmem_req, dmem_we, alu_enable, cpsr_write, reg_write;
    logic link_write, pc_write, pc_src, mem_fault;
    logic [1:0] wb_sel;
    logic [31:0] instr_retired;
    always #5 clk = ~clk;
    cpu_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .alu_code      (alu_code),
        .execute_flag  (execute_flag),
        .cpsr_enable   (cpsr_enable),
        .halt          (halt),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .alu_enable    (alu_enable),
        .cpsr_write    (cpsr_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .link_write    (link_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .mem_fault     (mem_fault),
        .instr_retired (instr_retired)
    );
    typedef struct {
        int imem, ir, alu, cpsr, regw, wb, link, dmem, we, cyc, pcsrc, cnt;
    } rec_t;
    rec_t sb[$];
    int checks = 0, passes = 0, exp_cnt = 0;
    int pool[15] = '{0, 3, 7, 8, 9, 10, 11, 12, 13, 31, 32, 41, 42, 20, 63};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int outs();
        return int'(imem_req) + int'(ir_write) + int'(dmem_req) + int'(dmem_we) + int'(alu_enable) +
               int'(cpsr_write) + int'(reg_write) + int'(wb_sel) + int'(link_write) + int'(pc_write) +
               int'(pc_src);
    endfunction

    // Per-instruction summary: strobe cycle counts plus decode-to-retire length.
    function automatic rec_t model(int code, bit flag, bit s, int ni, int nd, int cnt);
        rec_t r;
        bit dp = code <= 7 || code == 11 || code == 12;
        bit cmp = code inside {8, 9, 10, 13};
        bit br = code == 31 || code == 32;
        bit bl = code == 32;
        bit ld = code == 41;
        bit st = code == 42;
        bit ex = flag && (dp || cmp || br || ld || st);
        r.imem = ni;
        r.ir = 1;
        r.alu = ex ? 1 : 0;
        r.cpsr = ex && (cmp || (dp && s)) ? 1 : 0;
        r.regw = ex && (dp || ld || bl) ? 1 : 0;
        r.wb = r.regw == 0 ? 0 : ld ? 1 : bl ? 2 : 0;
        r.link = ex && bl ? 1 : 0;
        r.dmem = ex && (ld || st) ? nd : 0;
        r.we = ex && st ? nd : 0;
        r.pcsrc = ex && br ? 1 : 0;
        r.cyc = 1 + (!ex ? 1 : dp ? 3 : cmp ? 2 : br ? 1 : ld ? nd + 3 : nd + 2);
        r.cnt = cnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1 chk("rst_async_req", int'(imem_req) + int'(dmem_req), 0);
        halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_outputs", outs(), 0);
        chk("rst_mem_fault", int'(mem_fault), 0);
        chk("rst_counter", int'(instr_retired), 0);
        halt = 1'b1;
        #2 rst = 1'b0;
        exp_cnt = 0;
        tick();
    endtask

    // Starts in a FETCH cycle; returns in the cycle after DECODE with decoder inputs scrambled.
    task automatic front(input int code, input bit flag, input bit s, input int ni, input int h);
        alu_code = 11'(code);
        execute_flag = flag;
        cpsr_enable = s;
        halt = 1'b1;
        repeat (h) tick();
        halt = 1'b0;
        for (int j = 1; j <= ni; j++) begin
            imem_ready = j == ni;
            tick();
        end
        imem_ready = 1'b0;
        tick();
        alu_code = 11'($urandom);
        execute_flag = 1'($urandom);
        cpsr_enable = 1'($urandom);
        halt = 1'($urandom);
    endtask

    task automatic run_instr(input int code, input bit flag, input bit s, input int ni, input int nd, input int h);
        rec_t e;
        e = model(code, flag, s, ni, nd, exp_cnt);
        sb.push_back(e);
        exp_cnt++;
        front(code, flag, s, ni, h);
        if (e.dmem > 0) begin
            tick();
            for (int j = 1; j <= nd; j++) begin
                dmem_ready = j == nd;
                tick();
            end
            dmem_ready = 1'b0;
        end
        for (int k = 0; k < 40 && !pc_write; k++) tick();
        chk("pc_write_seen", int'(pc_write), 1);
        tick();
    endtask

    initial begin
        int imem_n, ir_n, alu_n, cpsr_n, reg_n, wb_o, link_n, dmem_n, we_n, cyc_n, in_i;
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst || pc_write) begin
                if (!rst) begin
                    imem_n += int'(imem_req);
                    alu_n += int'(alu_enable);
                    cpsr_n += int'(cpsr_write);
                    reg_n += int'(reg_write);
                    link_n += int'(link_write);
                    if (reg_write) wb_o = int'(wb_sel);
                    cyc_n += in_i;
                    if (sb.size() == 0) chk("sb_has_entry", 0, 1);
                    else begin
                        e = sb.pop_front();
                        chk("imem_req_cycles", imem_n, e.imem);
                        chk("ir_write_pulses", ir_n, e.ir);
                        chk("alu_enable_cycles", alu_n, e.alu);
                        chk("cpsr_write_cycles", cpsr_n, e.cpsr);
                        chk("reg_write_cycles", reg_n, e.regw);
                        chk("wb_sel_at_write", wb_o, e.wb);
                        chk("link_write_cycles", link_n, e.link);
                        chk("dmem_req_cycles", dmem_n, e.dmem);
                        chk("dmem_we_cycles", we_n, e.we);
                        chk("decode_to_retire", cyc_n, e.cyc);
                        chk("pc_src_at_pc_write", int'(pc_src), e.pcsrc);
                        chk("instr_retired", int'(instr_retired), e.cnt);
                    end
                end
                {imem_n, ir_n, alu_n, cpsr_n, reg_n, wb_o, link_n, dmem_n, we_n, cyc_n, in_i} = '0;
            end else begin
                imem_n += int'(imem_req);
                ir_n += int'(ir_write);
                alu_n += int'(alu_enable);
                cpsr_n += int'(cpsr_write);
                reg_n += int'(reg_write);
                link_n += int'(link_write);
                dmem_n += int'(dmem_req);
                we_n += int'(dmem_we);
                if (reg_write) wb_o = int'(wb_sel);
                if (ir_write) in_i = 1;
                cyc_n += in_i;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        reset_dut();
        run_instr(0, 1, 0, 2, 0, 0);
        run_instr(8, 1, 0, 1, 0, 1);
        run_instr(32, 1, 0, 3, 0, 0);
        run_instr(41, 1, 0, 1, 5, 0);
        run_instr(42, 1, 1, 2, 3, 2);
        run_instr(0, 0, 0, 1, 0, 0);
        run_instr(1, 1, 1, 16, 0, 0);
        run_instr(41, 1, 1, 1, 16, 0);
        run_instr(31, 1, 0, 1, 0, 3);
        run_instr(20, 1, 0, 1, 0, 0);
        repeat (30) run_instr(pool[$urandom_range(0, 14)], $urandom_range(0, 4) != 0, 1'($urandom),
                              $urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 2));
        halt = 1'b0;
        imem_ready = 1'b0;
        repeat (15) tick();
        chk("pre_timeout_imem_req", int'(imem_req), 1);
        chk("pre_timeout_fault", int'(mem_fault), 0);
        tick();
        chk("imem_timeout_fault", int'(mem_fault), 1);
        chk("fault_outputs", outs(), 0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) tick();
        chk("fault_sticky", int'(mem_fault), 1);
        chk("fault_sticky_outputs", outs(), 0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset_dut();
        run_instr(0, 1, 1, 1, 0, 0);
        run_instr(9, 1, 1, 2, 0, 0);
        front(41, 1, 0, 1, 0);
        repeat (3) tick();
        chk("mem_dmem_req", int'(dmem_req), 1);
        #2 rst = 1'b1;
        #1 chk("abandon_dmem_req", int'(dmem_req), 0);
        reset_dut();
        front(42, 1, 1, 2, 1);
        repeat (16) tick();
        chk("pre_timeout_dmem_req", int'(dmem_req) + int'(dmem_we), 2);
        chk("pre_timeout_dmem_fault", int'(mem_fault), 0);
        tick();
        chk("dmem_timeout_fault", int'(mem_fault), 1);
        chk("dmem_fault_outputs", outs(), 0);
        reset_dut();
        repeat (5) run_instr(pool[$urandom_range(0, 14)], 1'b1, 1'($urandom),
                             $urandom_range(1, 3), $urandom_range(1, 3), 0);
        tick();
        chk("final_counter", int'(instr_retired), exp_cnt);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
